pwm_ramp_ctrl: RTL and testbench

Soft-start duty controller for the PWM datapath. It accepts a target duty over a valid/ready handshake and owns the period counter. It steps the applied duty toward the target by a programmable increment, changing it only at period boundaries so no output pulse is ever truncated. It sits between the register or command logic and the pin, driving loads such as motors and LEDs that must not see duty jumps.

---
 rtl/pwm_pkg.sv | 28 ++
 rtl/pwm_ramp_ctrl_if.sv | 9 +
 rtl/pwm_core.sv | 18 +
 rtl/pwm_ramp_ctrl.sv | 64 ++++++
 tb/tb_pwm_ramp_ctrl.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/pwm_pkg.sv
// pwm_pkg: shared constants, types and duty arithmetic for the PWM ramp controller
package pwm_pkg;
    localparam int PERIOD = 100;
    localparam int DW = 8;
    localparam int SW = 4;

    typedef logic [DW-1:0] duty_t;
    typedef logic [SW-1:0] step_t;
    typedef enum logic {IDLE, RAMP} state_t;

    function automatic duty_t clamp_duty(duty_t t);
        return (t > duty_t'(PERIOD)) ? duty_t'(PERIOD) : t;
    endfunction

    function automatic step_t min_step(step_t s);
        return (s == '0) ? step_t'(1) : s;
    endfunction

    // One saturating move from cur toward tgt; the extra bit catches overflow and underflow.
    function automatic duty_t ramp_step(duty_t cur, duty_t tgt, step_t st);
        logic [DW:0] up;
        logic [DW:0] dn;
        up = {1'b0, cur} + {{(DW+1-SW){1'b0}}, st};
        dn = {1'b0, cur} - {{(DW+1-SW){1'b0}}, st};
        if (tgt > cur) return (up > {1'b0, tgt}) ? tgt : up[DW-1:0];
        return (dn[DW] || dn[DW-1:0] < tgt) ? tgt : dn[DW-1:0];
    endfunction
endpackage

// File: rtl/pwm_ramp_ctrl_if.sv
// pwm_ramp_ctrl_if: target command handshake into the ramp controller
interface pwm_ramp_ctrl_if import pwm_pkg::*; ;
    logic  cmd_valid;
    logic  cmd_ready;
    duty_t cmd_target;
    step_t cmd_step;
    modport master (output cmd_valid, cmd_target, cmd_step, input cmd_ready);
    modport slave (input cmd_valid, cmd_target, cmd_step, output cmd_ready);
endinterface

// File: rtl/pwm_core.sv
// pwm_core: period counter, duty compare and end-of-period tick
module pwm_core import pwm_pkg::*; (
    input  logic  clk,
    input  logic  rst,
    input  logic  enable,
    input  duty_t duty,
    output logic  pwm_out,
    output logic  period_tick
);
    duty_t cnt;
    // Free-running period counter; disabling parks it at 0 so the next period starts whole.
    always_ff @(posedge clk) begin
        if (rst || !enable) cnt <= '0;
        else cnt <= (cnt == duty_t'(PERIOD-1)) ? '0 : cnt + duty_t'(1);
    end
    assign pwm_out = enable && (cnt < duty);
    assign period_tick = enable && (cnt == duty_t'(PERIOD-1));
endmodule

// File: rtl/pwm_ramp_ctrl.sv
// pwm_ramp_ctrl: soft-start duty controller stepping duty toward a target at period boundaries
module pwm_ramp_ctrl import pwm_pkg::*; (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    pwm_ramp_ctrl_if.slave        cmd,
    output logic                  pwm_out,
    output duty_t                 duty_cur,
    output logic                  busy,
    output logic                  period_tick
);
    state_t state;
    duty_t  target;
    step_t  step;
    duty_t  cmd_tgt;
    duty_t  next_duty;
    logic   ready_q;

    assign cmd.cmd_ready = ready_q;

    // Clamped incoming target and the next ramp value, both ready before the period edge.
    always_comb begin
        cmd_tgt = clamp_duty(cmd.cmd_target);
        next_duty = ramp_step(duty_cur, target, step);
    end

    // Controller: accept commands in IDLE, move duty only on period_tick while ramping.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            duty_cur <= '0;
            target <= '0;
            step <= step_t'(1);
            busy <= 1'b0;
            ready_q <= 1'b1;
        end else if (state == IDLE) begin
            if (cmd.cmd_valid) begin
                target <= cmd_tgt;
                step <= min_step(cmd.cmd_step);
                if (cmd_tgt != duty_cur) begin
                    state <= RAMP;
                    busy <= 1'b1;
                    ready_q <= 1'b0;
                end
            end
        end else if (period_tick) begin
            duty_cur <= next_duty;
            if (next_duty == target) begin
                state <= IDLE;
                busy <= 1'b0;
                ready_q <= 1'b1;
            end
        end
    end

    pwm_core u_core (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .duty        (duty_cur),
        .pwm_out     (pwm_out),
        .period_tick (period_tick)
    );
endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// tb_pwm_ramp_ctrl: scoreboard bench for the PWM ramp controller
module tb_pwm_ramp_ctrl;
    import pwm_pkg::*;

    localparam int PER = 100;

    logic  clk = 1'b0;
    logic  rst;
    logic  enable;
    logic  pwm_out;
    duty_t duty_cur;
    logic  busy;
    logic  period_tick;

    pwm_ramp_ctrl_if bus ();

    pwm_ramp_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .cmd         (bus),
        .pwm_out     (pwm_out),
        .duty_cur    (duty_cur),
        .busy        (busy),
        .period_tick (period_tick)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int exp_q[$];
    int m_duty = 0;
    int hi = 0;
    logic pend = 1'b0;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Monitor: scoreboard pop after each ramp tick, per-period high time, disabled output.
    always @(negedge clk) begin
        if (pend) begin
            pend = 1'b0;
            if (exp_q.size() == 0) chk("sb_underflow", int'(duty_cur), -1);
            else begin
                chk("sb_duty", int'(duty_cur), exp_q.pop_front());
                chk("sb_busy", int'(busy), int'(exp_q.size() != 0));
            end
        end
        if (rst) begin
            hi = 0;
        end else if (!enable) begin
            hi = 0;
            chk("dis_pwm", int'(pwm_out), 0);
            chk("dis_tick", int'(period_tick), 0);
        end else begin
            hi += int'(pwm_out);
            if (period_tick) begin
                chk("high_time", hi, int'(duty_cur));
                hi = 0;
                if (busy) pend = 1'b1;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input int t, input int s);
        int n;
        int ct;
        int cs;
        int d;
        n = 0;
        while (!bus.cmd_ready && n < 20000) begin
            cyc();
            n++;
        end
        if (n >= 20000) chk("ready_timeout", 0, 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_target = duty_t'(t);
        bus.cmd_step = step_t'(s);
        cyc();
        bus.cmd_valid = 1'b0;
        ct = (t > PER) ? PER : t;
        cs = (s == 0) ? 1 : s;
        chk("busy_after_cmd", int'(busy), int'(ct != m_duty));
        chk("ready_after_cmd", int'(bus.cmd_ready), int'(ct == m_duty));
        d = m_duty;
        while (d != ct) begin
            if (ct > d) d = (d + cs > ct) ? ct : d + cs;
            else d = (d - cs < ct) ? ct : d - cs;
            exp_q.push_back(d);
        end
        m_duty = ct;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!(bus.cmd_ready && exp_q.size() == 0) && n < 15000) begin
            cyc();
            n++;
        end
        if (n >= 15000) chk("idle_timeout", 0, 1);
        chk("final_duty", int'(duty_cur), m_duty);
        chk("final_busy", int'(busy), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ticks;
        int highs;
        int n;
        rst = 1'b1;
        enable = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_target = '0;
        bus.cmd_step = '0;
        repeat (3) cyc();
        rst = 1'b0;
        cyc();
        chk("rst_duty", int'(duty_cur), 0);
        chk("rst_ready", int'(bus.cmd_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_pwm", int'(pwm_out), 0);
        chk("rst_tick", int'(period_tick), 0);

        enable = 1'b1;
        ticks = 0;
        highs = 0;
        repeat (300) begin
            @(negedge clk);
            ticks += int'(period_tick);
            highs += int'(pwm_out);
        end
        chk("idle_ticks", ticks, 3);
        chk("idle_highs", highs, 0);
        chk("idle_ready", int'(bus.cmd_ready), 1);
        cyc();

        send(40, 10);
        wait_idle();

        send(200, 0);
        bus.cmd_valid = 1'b1;
        bus.cmd_target = duty_t'(5);
        bus.cmd_step = step_t'(3);
        repeat (50) cyc();
        chk("hold_ready", int'(bus.cmd_ready), 0);
        chk("hold_busy", int'(busy), 1);
        bus.cmd_valid = 1'b0;
        wait_idle();
        chk("full_pwm", int'(pwm_out), 1);

        send(50, 10);
        wait_idle();
        send(3, 15);
        wait_idle();
        send(3, 1);
        repeat (5) cyc();
        chk("same_busy", int'(busy), 0);
        chk("same_ready", int'(bus.cmd_ready), 1);

        send(0, 15);
        wait_idle();
        send(60, 10);
        n = 0;
        while (duty_cur != duty_t'(20) && n < 1000) begin
            cyc();
            n++;
        end
        chk("reach_20", int'(duty_cur), 20);
        repeat (30) cyc();
        enable = 1'b0;
        repeat (37) cyc();
        chk("dis_duty", int'(duty_cur), 20);
        chk("dis_busy", int'(busy), 1);
        enable = 1'b1;
        n = 0;
        while (duty_cur == duty_t'(20) && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("resume_latency", n, 100);
        #1;
        wait_idle();

        send(90, 10);
        repeat (5) cyc();
        rst = 1'b1;
        exp_q.delete();
        m_duty = 0;
        cyc();
        rst = 1'b0;
        chk("mid_rst_duty", int'(duty_cur), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_ready", int'(bus.cmd_ready), 1);
        chk("mid_rst_pwm", int'(pwm_out), 0);
        chk("mid_rst_tick", int'(period_tick), 0);
        send(10, 4);
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
